// File: rtl/defl_port_alloc_if.sv
// Flit-request and grant bundle between the route-compute stage and the deflection port allocator.
interface defl_port_alloc_if #(
    parameter int NUM_PORT = 5,
    parameter int AGE_W    = 8
);
    logic [3:0]            in_valid;
    logic [4*NUM_PORT-1:0] in_prefer;
    logic [4*AGE_W-1:0]    in_age;
    logic                  inj_valid;
    logic [NUM_PORT-1:0]   inj_prefer;
    logic                  inj_accept;
    logic [3:0]            out_valid;
    logic [11:0]           out_sel;
    logic [3:0]            out_defl;
    logic                  ej_valid;
    logic [1:0]            ej_sel;

    modport master (
        output in_valid, in_prefer, in_age, inj_valid, inj_prefer,
        input  inj_accept, out_valid, out_sel, out_defl, ej_valid, ej_sel
    );

    modport slave (
        input  in_valid, in_prefer, in_age, inj_valid, inj_prefer,
        output inj_accept, out_valid, out_sel, out_defl, ej_valid, ej_sel
    );
endinterface

// File: rtl/defl_port_alloc.sv
// Registered output-port allocator for the bufferless deflection router: ranks up to four network
// flits by age, places each on a distinct output or the ejection port, then offers leftovers to injection.
module defl_port_alloc #(
    parameter int NUM_PORT = 5,
    parameter int AGE_W    = 8,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    defl_port_alloc_if.slave bus,
    output logic [CNT_W-1:0] defl_cnt
);
    localparam logic [NUM_PORT-1:0] PREF_LOCAL = {1'b1, {(NUM_PORT-1){1'b0}}};

    logic [1:0]       rr_ptr;
    logic [2:0]       rank [4];
    logic [3:0]       net_free;
    logic             ej_free;
    logic [NUM_PORT-1:0] pref;
    logic [1:0]       port;
    logic             miss;
    logic             inj_named;
    logic [3:0]       valid_nxt;
    logic [3:0]       defl_nxt;
    logic [11:0]      sel_nxt;
    logic             ej_nxt;
    logic [1:0]       ej_sel_nxt;
    logic             inj_nxt;
    logic [2:0]       defl_pc;
    logic [CNT_W:0]   cnt_sum;

    function automatic logic [1:0] first_set(input logic [3:0] v);
        first_set = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (v[k]) first_set = 2'(k);
        end
    endfunction

    function automatic logic [1:0] rr_pos(input int k, input logic [1:0] ptr);
        rr_pos = 2'(k) - ptr;
    endfunction

    // A flit's rank is the number of valid flits that beat it: older first, then rotating order.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            rank[i] = 3'd0;
            for (int j = 0; j < 4; j++) begin
                if (j != i && bus.in_valid[j]) begin
                    if (bus.in_age[j*AGE_W +: AGE_W] > bus.in_age[i*AGE_W +: AGE_W] ||
                        (bus.in_age[j*AGE_W +: AGE_W] == bus.in_age[i*AGE_W +: AGE_W] &&
                         rr_pos(j, rr_ptr) < rr_pos(i, rr_ptr)))
                        rank[i] = rank[i] + 3'd1;
                end
            end
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        net_free   = 4'hF;
        ej_free    = 1'b1;
        pref       = '0;
        port       = 2'd0;
        miss       = 1'b0;
        inj_named  = 1'b0;
        valid_nxt  = '0;
        defl_nxt   = '0;
        sel_nxt    = '0;
        ej_nxt     = 1'b0;
        ej_sel_nxt = 2'd0;
        inj_nxt    = 1'b0;

        // NOTE: blocking assignments here so each placement sees the ports taken by higher-ranked flits.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.in_valid[i] && rank[i] == 3'(r)) begin
                    pref = bus.in_prefer[i*NUM_PORT +: NUM_PORT];
                    if (pref == PREF_LOCAL && ej_free) begin
                        ej_free    = 1'b0;
                        ej_nxt     = 1'b1;
                        ej_sel_nxt = 2'(i);
                    end else begin
                        port = first_set(net_free);
                        miss = 1'b1;
                        if (!pref[4] && $onehot(pref[3:0]) && (pref[3:0] & net_free) != 4'h0) begin
                            port = first_set(pref[3:0]);
                            miss = 1'b0;
                        end
                        net_free[port]       = 1'b0;
                        valid_nxt[port]      = 1'b1;
                        sel_nxt[port*3 +: 3] = 3'(i);
                        defl_nxt[port]       = miss;
                    end
                end
            end
        end

        // Injection only competes for what the network flits left behind.
        if (bus.inj_valid && net_free != 4'h0) begin
            inj_nxt   = 1'b1;
            inj_named = !bus.inj_prefer[4] && $onehot(bus.inj_prefer[3:0]);
            port      = first_set(net_free);
            miss      = inj_named;
            if (inj_named && (bus.inj_prefer[3:0] & net_free) != 4'h0) begin
                port = first_set(bus.inj_prefer[3:0]);
                miss = 1'b0;
            end
            valid_nxt[port]      = 1'b1;
            sel_nxt[port*3 +: 3] = 3'd4;
            defl_nxt[port]       = miss;
        end
    end

    assign defl_pc = 3'($countones(defl_nxt));
    assign cnt_sum = {1'b0, defl_cnt} + (CNT_W+1)'(defl_pc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid  <= '0;
            bus.out_sel    <= '0;
            bus.out_defl   <= '0;
            bus.ej_valid   <= 1'b0;
            bus.ej_sel     <= 2'd0;
            bus.inj_accept <= 1'b0;
            rr_ptr         <= 2'd0;
            defl_cnt       <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values of the others.
            bus.out_valid  <= valid_nxt;
            bus.out_sel    <= sel_nxt;
            bus.out_defl   <= defl_nxt;
            bus.ej_valid   <= ej_nxt;
            bus.ej_sel     <= ej_sel_nxt;
            bus.inj_accept <= inj_nxt;
            if (|bus.in_valid) rr_ptr <= rr_ptr + 2'd1;
            defl_cnt <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
        end
    end
endmodule

// File: tb/tb_defl_port_alloc.sv
// Self-checking bench for defl_port_alloc: directed vector table, randomized traffic against
// a behavioural model, asynchronous reset and counter saturation sequences.
module tb_defl_port_alloc;
    localparam logic [4:0] PN = 5'b00001;
    localparam logic [4:0] PE = 5'b00010;
    localparam logic [4:0] PS = 5'b00100;
    localparam logic [4:0] PW = 5'b01000;
    localparam logic [4:0] PL = 5'b10000;
    localparam logic [4:0] P0 = 5'b00000;

    typedef struct {
        logic [3:0]  v;
        logic [19:0] pf;
        logic [31:0] ag;
        logic        iv;
        logic [4:0]  ip;
        logic [3:0]  ov;
        logic [11:0] sel;
        logic [3:0]  dfl;
        logic        ej;
        logic [1:0]  ejs;
        logic        inj;
        int          cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    defl_port_alloc_if #(.NUM_PORT(5), .AGE_W(8)) bus ();
    defl_port_alloc_if #(.NUM_PORT(5), .AGE_W(8)) bus_s ();
    logic [15:0] defl_cnt;
    logic [3:0]  defl_cnt_s;

    defl_port_alloc #(.NUM_PORT(5), .AGE_W(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .defl_cnt(defl_cnt));
    defl_port_alloc #(.NUM_PORT(5), .AGE_W(8), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .bus(bus_s), .defl_cnt(defl_cnt_s));

    int n_vec = 0;
    int n_err = 0;
    int m_rr  = 0;
    int m_cnt = 0;
    logic [3:0]  e_ov;
    logic [11:0] e_sel;
    logic [3:0]  e_dfl;
    logic        e_ej;
    logic [1:0]  e_ejs;
    logic        e_inj;

    function automatic logic [19:0] pf4(input logic [4:0] p0, p1, p2, p3);
        return {p3, p2, p1, p0};
    endfunction

    function automatic logic [31:0] ag4(input logic [7:0] a0, a1, a2, a3);
        return {a3, a2, a1, a0};
    endfunction

    // Network port a preference vector names, or -1 when it names none.
    function automatic int net_port(input logic [4:0] p);
        if (p[4] || $countones(p[3:0]) != 1) return -1;
        for (int k = 0; k < 4; k++) if (p[k]) return k;
        return -1;
    endfunction

    function automatic int lowest_free(input bit taken [4]);
        for (int k = 0; k < 4; k++) if (!taken[k]) return k;
        return -1;
    endfunction

    task automatic ref_alloc(input logic [3:0] v, input logic [19:0] pf, input logic [31:0] ag,
                             input logic iv, input logic [4:0] ip, input int rr,
                             output logic [3:0] ov, output logic [11:0] sel, output logic [3:0] dfl,
                             output logic ej, output logic [1:0] ejs, output logic inj);
        bit done [4];
        bit taken [4];
        int order [$];
        ov = '0; sel = '0; dfl = '0; ej = 1'b0; ejs = '0; inj = 1'b0;
        foreach (done[k]) begin done[k] = 1'b0; taken[k] = 1'b0; end
        // Repeatedly pick the oldest remaining flit; scanning in rotating order settles ties.
        for (int n = 0; n < 4; n++) begin
            int best = -1;
            for (int k = 0; k < 4; k++) begin
                int i = (rr + k) % 4;
                if (v[i] && !done[i] && (best < 0 || ag[8*i +: 8] > ag[8*best +: 8])) best = i;
            end
            if (best >= 0) begin done[best] = 1'b1; order.push_back(best); end
        end
        foreach (order[n]) begin
            int i = order[n];
            logic [4:0] p = pf[5*i +: 5];
            int want = net_port(p);
            if (p == PL && !ej) begin
                ej = 1'b1; ejs = 2'(i);
            end else begin
                int got = (want >= 0 && !taken[want]) ? want : lowest_free(taken);
                taken[got] = 1'b1; ov[got] = 1'b1; sel[3*got +: 3] = 3'(i);
                dfl[got] = !(want >= 0 && got == want);
            end
        end
        if (iv && lowest_free(taken) >= 0) begin
            int want = net_port(ip);
            int got = (want >= 0 && !taken[want]) ? want : lowest_free(taken);
            inj = 1'b1; ov[got] = 1'b1; sel[3*got +: 3] = 3'd4;
            dfl[got] = (want >= 0 && got != want);
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic [19:0] pf, input logic [31:0] ag,
                         input logic iv, input logic [4:0] ip);
        bus.in_valid = v; bus.in_prefer = pf; bus.in_age = ag;
        bus.inj_valid = iv; bus.inj_prefer = ip;
    endtask

    // One allocation: model the currently driven inputs, clock, then advance the model state.
    task automatic step();
        ref_alloc(bus.in_valid, bus.in_prefer, bus.in_age, bus.inj_valid, bus.inj_prefer, m_rr,
                  e_ov, e_sel, e_dfl, e_ej, e_ejs, e_inj);
        @(posedge clk);
        #1;
        if (bus.in_valid != 4'h0) m_rr = (m_rr + 1) % 4;
        m_cnt = m_cnt + $countones(e_dfl);
        if (m_cnt > 65535) m_cnt = 65535;
    endtask

    task automatic check_all(input string tag, input logic [3:0] ov, input logic [11:0] sel,
                             input logic [3:0] dfl, input logic ej, input logic [1:0] ejs,
                             input logic inj, input int cnt);
        check({tag, " out_valid"},  32'(bus.out_valid),  32'(ov));
        check({tag, " out_sel"},    32'(bus.out_sel),    32'(sel));
        check({tag, " out_defl"},   32'(bus.out_defl),   32'(dfl));
        check({tag, " ej_valid"},   32'(bus.ej_valid),   32'(ej));
        check({tag, " ej_sel"},     32'(bus.ej_sel),     32'(ejs));
        check({tag, " inj_accept"}, 32'(bus.inj_accept), 32'(inj));
        check({tag, " defl_cnt"},   32'(defl_cnt),       32'(cnt));
    endtask

    function automatic logic [4:0] rand_pref();
        int r = $urandom_range(0, 9);
        if (r < 5) return 5'(1 << r);
        if (r < 8) return 5'($urandom_range(0, 31));
        return 5'd0;
    endfunction

    initial begin
        vec_t tbl [11];
        int guard;
        tbl[0]  = '{4'b0100, pf4(P0, P0, PE, P0), 32'h0, 1'b0, P0,
                    4'b0010, 12'h010, 4'b0000, 1'b0, 2'd0, 1'b0, 0};
        tbl[1]  = '{4'b0011, pf4(PE, PE, P0, P0), ag4(8'd5, 8'd9, 8'd0, 8'd0), 1'b0, P0,
                    4'b0011, 12'h008, 4'b0001, 1'b0, 2'd0, 1'b0, 1};
        tbl[2]  = '{4'b0001, pf4(PN, P0, P0, P0), 32'h0, 1'b0, P0,
                    4'b0001, 12'h000, 4'b0000, 1'b0, 2'd0, 1'b0, 1};
        tbl[3]  = '{4'b1001, pf4(PS, P0, P0, PS), ag4(8'd4, 8'd0, 8'd0, 8'd4), 1'b0, P0,
                    4'b0101, 12'h0C0, 4'b0001, 1'b0, 2'd0, 1'b0, 2};
        tbl[4]  = '{4'b0110, pf4(P0, PL, PL, P0), ag4(8'd0, 8'd7, 8'd2, 8'd0), 1'b0, P0,
                    4'b0001, 12'h002, 4'b0001, 1'b1, 2'd1, 1'b0, 3};
        tbl[5]  = '{4'b1111, pf4(PN, PE, PS, PW), ag4(8'd1, 8'd1, 8'd1, 8'd1), 1'b1, PW,
                    4'b1111, 12'h688, 4'b0000, 1'b0, 2'd0, 1'b0, 3};
        tbl[6]  = '{4'b0111, pf4(PN, PE, PS, PW), ag4(8'd1, 8'd1, 8'd1, 8'd1), 1'b1, PW,
                    4'b1111, 12'h888, 4'b0000, 1'b0, 2'd0, 1'b1, 3};
        tbl[7]  = '{4'b0000, 20'h0, 32'h0, 1'b1, PL,
                    4'b0001, 12'h004, 4'b0000, 1'b0, 2'd0, 1'b1, 3};
        tbl[8]  = '{4'b0000, 20'h0, 32'h0, 1'b0, P0,
                    4'b0000, 12'h000, 4'b0000, 1'b0, 2'd0, 1'b0, 3};
        tbl[9]  = '{4'b0001, pf4(PW, P0, P0, P0), ag4(8'd3, 8'd0, 8'd0, 8'd0), 1'b1, PW,
                    4'b1001, 12'h004, 4'b0001, 1'b0, 2'd0, 1'b1, 4};
        tbl[10] = '{4'b0010, 20'h0, 32'h0, 1'b0, P0,
                    4'b0001, 12'h001, 4'b0001, 1'b0, 2'd0, 1'b0, 5};

        bus_s.in_valid = '0; bus_s.in_prefer = '0; bus_s.in_age = '0;
        bus_s.inj_valid = 1'b0; bus_s.inj_prefer = '0;

        // Reset held with live inputs: outputs must be clear before any clock edge.
        drive(4'b1111, pf4(PN, PE, PS, PW), 32'h0, 1'b1, PW);
        #2;
        check_all("reset", 4'h0, 12'h0, 4'h0, 1'b0, 2'd0, 1'b0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[r]) begin
            drive(tbl[r].v, tbl[r].pf, tbl[r].ag, tbl[r].iv, tbl[r].ip);
            step();
            check_all($sformatf("row%0d", r), tbl[r].ov, tbl[r].sel, tbl[r].dfl,
                      tbl[r].ej, tbl[r].ejs, tbl[r].inj, tbl[r].cnt);
        end

        for (int c = 0; c < 400; c++) begin
            logic [7:0] a [4];
            foreach (a[k]) a[k] = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(250, 255))
                                                              : 8'($urandom_range(0, 3));
            drive(4'($urandom_range(0, 15)), pf4(rand_pref(), rand_pref(), rand_pref(), rand_pref()),
                  ag4(a[0], a[1], a[2], a[3]), 1'($urandom_range(0, 1)), rand_pref());
            step();
            check_all($sformatf("rnd%0d", c), e_ov, e_sel, e_dfl, e_ej, e_ejs, e_inj, m_cnt);
        end

        // Bring the rotating pointer to 1, then reset mid-cycle and confirm the pointer restarts at 0.
        guard = 0;
        while (m_rr != 0 && guard < 8) begin
            drive(4'b0001, pf4(PN, P0, P0, P0), 32'h0, 1'b0, P0);
            step();
            guard++;
        end
        check("rr align", 32'(m_rr), 32'd0);
        drive(4'b1111, pf4(PN, PN, PN, PN), 32'h0, 1'b0, P0);
        step();
        check_all("pre-reset", e_ov, e_sel, e_dfl, e_ej, e_ejs, e_inj, m_cnt);
        #2 rst_n = 1'b0;
        #1;
        check_all("async reset", 4'h0, 12'h0, 4'h0, 1'b0, 2'd0, 1'b0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        m_rr = 0;
        m_cnt = 0;
        drive(4'b0011, pf4(PN, PN, P0, P0), ag4(8'd6, 8'd6, 8'd0, 8'd0), 1'b0, P0);
        step();
        check_all("post-reset tie", 4'b0011, 12'h008, 4'b0010, 1'b0, 2'd0, 1'b0, 1);
        drive(4'b0000, 20'h0, 32'h0, 1'b0, P0);

        // Four flits chasing N give three deflections per cycle on the 4-bit counter.
        bus_s.in_valid = 4'b1111;
        bus_s.in_prefer = pf4(PN, PN, PN, PN);
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("sat cyc%0d defl_cnt", k), 32'(defl_cnt_s), (k * 3 > 15) ? 32'd15 : 32'(k * 3));
        end
        check("sat out_defl", 32'(bus_s.out_defl), 32'h0000000E);
        bus_s.in_valid = '0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
